// File: rtl/time_of_day_transmitter_if.sv
// Signal bundle of the time-of-day transmitter: pps/event inputs, merged stream and status outputs.
// The master side drives the inputs; the slave side is the transmitter itself.
interface time_of_day_transmitter_if;
    logic        ppsIn;
    logic [7:0]  upEvent;
    logic [31:0] secondsLoad;
    logic        secondsLoadStrobe;
    logic [7:0]  EventStream;
    logic [31:0] secondsNext;
    logic [9:0]  abortCount;
    logic [9:0]  overrunCount;
    logic        busy;

    modport master (
        output ppsIn,
        output upEvent,
        output secondsLoad,
        output secondsLoadStrobe,
        input  EventStream,
        input  secondsNext,
        input  abortCount,
        input  overrunCount,
        input  busy
    );

    modport slave (
        input  ppsIn,
        input  upEvent,
        input  secondsLoad,
        input  secondsLoadStrobe,
        output EventStream,
        output secondsNext,
        output abortCount,
        output overrunCount,
        output busy
    );
endinterface

// File: rtl/time_of_day_transmitter.sv
// Merges upstream event codes with a seconds marker on each pps edge, followed by
// a 32-bit serial announcement of the seconds value sent as shift-zero/shift-one events.
module time_of_day_transmitter #(
    parameter int unsigned BIT_SPACING = 8,
    parameter int unsigned SHIFT_DELAY = 16
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    time_of_day_transmitter_if.slave     tod
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHIFT_WAIT = 2'd1,
        ST_SHIFT_DUE  = 2'd2
    } state_e;

    localparam logic [7:0] EVT_NONE    = 8'h00;
    localparam logic [7:0] EVT_SHIFT0  = 8'h70;
    localparam logic [7:0] EVT_MARKER  = 8'h7D;
    localparam logic [7:0] SPACING_C   = 8'(BIT_SPACING);
    localparam logic [7:0] DELAY_C     = 8'(SHIFT_DELAY);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'd1023) ? v : (v + 10'd1);
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] shift_reg_q, shift_reg_d;
    logic [5:0]  bits_left_q, bits_left_d;
    logic [31:0] seconds_next_q, seconds_next_d;
    logic [9:0]  abort_q, abort_d;
    logic [9:0]  overrun_q, overrun_d;
    logic        marker_pending_q, marker_pending_d;
    logic        pps_prev_q, pps_prev_d;
    logic [7:0]  event_q, event_d;
    logic        busy_q, busy_d;

    logic        pps_edge_s;
    logic        marker_emit_s;
    logic        shift_emit_s;

    // Next-state: output arbitration, shift sequencing, marker, pps edge and load handling
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        shift_reg_d      = shift_reg_q;
        bits_left_d      = bits_left_q;
        seconds_next_d   = seconds_next_q;
        abort_d          = abort_q;
        overrun_d        = overrun_q;
        marker_pending_d = marker_pending_q;
        pps_prev_d       = tod.ppsIn;
        event_d          = EVT_NONE;
        marker_emit_s    = 1'b0;
        shift_emit_s     = 1'b0;
        pps_edge_s       = tod.ppsIn & ~pps_prev_q;

        // Upstream traffic always wins; deferred marker/shift simply stays pending
        if (tod.upEvent != EVT_NONE) begin
            event_d = tod.upEvent;
        end else if (marker_pending_q) begin
            event_d       = EVT_MARKER;
            marker_emit_s = 1'b1;
        end else if (state_q == ST_SHIFT_DUE) begin
            event_d      = EVT_SHIFT0 | {7'd0, shift_reg_q[31]};
            shift_emit_s = 1'b1;
        end else begin
            event_d = EVT_NONE;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT_WAIT: begin
                // Leaving one cycle early makes the event land exactly N+1 cycles later
                if (cnt_q <= 8'd1) begin
                    state_d = ST_SHIFT_DUE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SHIFT_DUE: begin
                if (shift_emit_s) begin
                    shift_reg_d = {shift_reg_q[30:0], 1'b0};
                    bits_left_d = bits_left_q - 6'd1;
                    if (bits_left_q > 6'd1) begin
                        state_d = ST_SHIFT_WAIT;
                        cnt_d   = SPACING_C;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SHIFT_DUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (marker_emit_s) begin
            marker_pending_d = 1'b0;
            seconds_next_d   = seconds_next_q + 32'd1;
            shift_reg_d      = seconds_next_q + 32'd1;
            bits_left_d      = 6'd32;
            state_d          = ST_SHIFT_WAIT;
            cnt_d            = DELAY_C;
            if (state_q != ST_IDLE) begin
                abort_d = sat_inc(abort_q);
            end else begin
                abort_d = abort_q;
            end
        end else begin
            abort_d = abort_q;
        end

        // A new edge while a marker is still waiting collapses into that single marker
        if (pps_edge_s) begin
            marker_pending_d = 1'b1;
            if (marker_pending_q && !marker_emit_s) begin
                overrun_d = sat_inc(overrun_q);
            end else begin
                overrun_d = overrun_q;
            end
        end else begin
            overrun_d = overrun_q;
        end

        if (tod.secondsLoadStrobe) begin
            seconds_next_d = tod.secondsLoad;
            if ((state_q != ST_IDLE) || marker_emit_s) begin
                shift_reg_d = tod.secondsLoad;
                bits_left_d = 6'd32;
                state_d     = ST_SHIFT_WAIT;
                cnt_d       = SPACING_C;
            end else begin
                shift_reg_d = shift_reg_d;
            end
        end else begin
            seconds_next_d = seconds_next_d;
        end

        busy_d = marker_pending_d | (state_d != ST_IDLE);
    end

    // State and output registers; pps history resets high so a level at release is no edge
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 8'd0;
            shift_reg_q      <= 32'd0;
            bits_left_q      <= 6'd0;
            seconds_next_q   <= 32'd0;
            abort_q          <= 10'd0;
            overrun_q        <= 10'd0;
            marker_pending_q <= 1'b0;
            pps_prev_q       <= 1'b1;
            event_q          <= 8'h00;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            shift_reg_q      <= shift_reg_d;
            bits_left_q      <= bits_left_d;
            seconds_next_q   <= seconds_next_d;
            abort_q          <= abort_d;
            overrun_q        <= overrun_d;
            marker_pending_q <= marker_pending_d;
            pps_prev_q       <= pps_prev_d;
            event_q          <= event_d;
            busy_q           <= busy_d;
        end
    end

    assign tod.EventStream  = event_q;
    assign tod.secondsNext  = seconds_next_q;
    assign tod.abortCount   = abort_q;
    assign tod.overrunCount = overrun_q;
    assign tod.busy         = busy_q;

endmodule

// File: tb/tb_time_of_day_transmitter.sv
// Directed bench for time_of_day_transmitter: marker timing, serial seconds encoding,
// upstream priority, abort/overrun counting, load restart and mid-sequence reset.
module tb_time_of_day_transmitter;

    localparam int BS = 8;
    localparam int SD = 16;

    logic Clock;
    logic Reset_n;
    int   n_total;
    int   n_bad;

    time_of_day_transmitter_if tod_if();

    time_of_day_transmitter #(
        .BIT_SPACING (BS),
        .SHIFT_DELAY (SD)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .tod     (tod_if)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // n-1 quiet cycles then the expected code on the n-th
    task automatic wait_code(input int n, input logic [7:0] exp, input string tag);
        for (int k = 0; k < n - 1; k++) begin
            tick();
            chk("gap", {24'd0, tod_if.EventStream}, 32'd0);
        end
        tick();
        chk(tag, {24'd0, tod_if.EventStream}, {24'd0, exp});
    endtask

    task automatic run_seq(input logic [31:0] val, input int nbits, input int first_gap);
        logic [7:0] code;
        for (int i = 0; i < nbits; i++) begin
            code = 8'h70 | {7'd0, val[31 - i]};
            wait_code((i == 0) ? first_gap : (BS + 1), code, "shift");
        end
    endtask

    task automatic load(input logic [31:0] v);
        tod_if.secondsLoad       = v;
        tod_if.secondsLoadStrobe = 1'b1;
        tick();
        tod_if.secondsLoadStrobe = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        Reset_n = 1'b0;
        tod_if.ppsIn             = 1'b1;
        tod_if.upEvent           = 8'h00;
        tod_if.secondsLoad       = 32'd0;
        tod_if.secondsLoadStrobe = 1'b0;
        repeat (3) tick();
        Reset_n = 1'b1;
        tick();
        chk("rst_evt", {24'd0, tod_if.EventStream}, 32'd0);
        chk("rst_sec", tod_if.secondsNext, 32'd0);
        chk("rst_abort", {22'd0, tod_if.abortCount}, 32'd0);
        chk("rst_ovr", {22'd0, tod_if.overrunCount}, 32'd0);
        // ppsIn high through release must not count as an edge
        chk("rst_busy", {31'd0, tod_if.busy}, 32'd0);
        tod_if.ppsIn = 1'b0;
        tick();
        chk("no_edge_busy", {31'd0, tod_if.busy}, 32'd0);

        // Basic marker plus 32-bit announcement
        load(32'h5A5A_0000);
        chk("load_sec", tod_if.secondsNext, 32'h5A5A_0000);
        tod_if.ppsIn = 1'b1;
        tick();
        tod_if.ppsIn = 1'b0;
        chk("edge_evt", {24'd0, tod_if.EventStream}, 32'd0);
        chk("edge_busy", {31'd0, tod_if.busy}, 32'd1);
        tick();
        chk("marker1", {24'd0, tod_if.EventStream}, 32'h7D);
        chk("sec1", tod_if.secondsNext, 32'h5A5A_0001);
        run_seq(32'h5A5A_0001, 32, SD + 1);
        chk("seq1_idle", {31'd0, tod_if.busy}, 32'd0);

        // Upstream event held across the marker cycle
        tod_if.upEvent = 8'h2A;
        tod_if.ppsIn   = 1'b1;
        tick();
        tod_if.ppsIn = 1'b0;
        chk("up0", {24'd0, tod_if.EventStream}, 32'h2A);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("up_n", {24'd0, tod_if.EventStream}, 32'h2A);
        end
        tod_if.upEvent = 8'h00;
        tick();
        chk("marker2", {24'd0, tod_if.EventStream}, 32'h7D);
        chk("sec2", tod_if.secondsNext, 32'h5A5A_0002);

        // Abort after ten shift events
        run_seq(32'h5A5A_0002, 10, SD + 1);
        tod_if.ppsIn = 1'b1;
        tick();
        tod_if.ppsIn = 1'b0;
        chk("abort_gap", {24'd0, tod_if.EventStream}, 32'd0);
        tick();
        chk("marker3", {24'd0, tod_if.EventStream}, 32'h7D);
        chk("abort1", {22'd0, tod_if.abortCount}, 32'd1);
        chk("sec3", tod_if.secondsNext, 32'h5A5A_0003);
        run_seq(32'h5A5A_0003, 32, SD + 1);
        chk("seq3_idle", {31'd0, tod_if.busy}, 32'd0);

        // Two edges while upstream traffic blocks the marker
        tod_if.upEvent = 8'h55;
        tod_if.ppsIn   = 1'b1;
        tick();
        chk("ovr_up0", {24'd0, tod_if.EventStream}, 32'h55);
        tod_if.ppsIn = 1'b0;
        tick();
        chk("ovr_up1", {24'd0, tod_if.EventStream}, 32'h55);
        tod_if.ppsIn = 1'b1;
        tick();
        chk("ovr_up2", {24'd0, tod_if.EventStream}, 32'h55);
        tod_if.ppsIn = 1'b0;
        tick();
        chk("ovr_up3", {24'd0, tod_if.EventStream}, 32'h55);
        chk("overrun1", {22'd0, tod_if.overrunCount}, 32'd1);
        chk("ovr_busy", {31'd0, tod_if.busy}, 32'd1);
        tod_if.upEvent = 8'h00;
        tick();
        chk("marker4", {24'd0, tod_if.EventStream}, 32'h7D);
        chk("sec4", tod_if.secondsNext, 32'h5A5A_0004);
        run_seq(32'h5A5A_0004, 32, SD + 1);
        chk("overrun_hold", {22'd0, tod_if.overrunCount}, 32'd1);
        chk("abort_hold", {22'd0, tod_if.abortCount}, 32'd1);

        // Seconds wrap
        load(32'hFFFF_FFFF);
        tod_if.ppsIn = 1'b1;
        tick();
        tod_if.ppsIn = 1'b0;
        tick();
        chk("marker5", {24'd0, tod_if.EventStream}, 32'h7D);
        chk("sec_wrap", tod_if.secondsNext, 32'd0);
        run_seq(32'd0, 32, SD + 1);

        // Load during an active sequence restarts from the MSB
        tod_if.ppsIn = 1'b1;
        tick();
        tod_if.ppsIn = 1'b0;
        tick();
        chk("marker6", {24'd0, tod_if.EventStream}, 32'h7D);
        chk("sec6", tod_if.secondsNext, 32'd1);
        run_seq(32'd1, 3, SD + 1);
        load(32'hC000_0000);
        chk("reload_evt", {24'd0, tod_if.EventStream}, 32'd0);
        chk("reload_sec", tod_if.secondsNext, 32'hC000_0000);
        chk("reload_abort", {22'd0, tod_if.abortCount}, 32'd1);
        run_seq(32'hC000_0000, 20, BS + 1);

        // Asynchronous reset in the middle of the sequence
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_evt", {24'd0, tod_if.EventStream}, 32'd0);
        chk("mid_rst_sec", tod_if.secondsNext, 32'd0);
        chk("mid_rst_abort", {22'd0, tod_if.abortCount}, 32'd0);
        chk("mid_rst_ovr", {22'd0, tod_if.overrunCount}, 32'd0);
        chk("mid_rst_busy", {31'd0, tod_if.busy}, 32'd0);
        repeat (2) tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("post_rst_quiet", {24'd0, tod_if.EventStream}, 32'd0);
        end
        chk("post_rst_busy", {31'd0, tod_if.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
